// File: rtl/mem_arbiter_multi_pkg.sv
// mem_arbiter_multi_pkg
// Shared constants for the two-port memory arbiter: FSM state encodings,
// the memory access latency, and a helper that forms the memory byte
// enables for a command.
package mem_arbiter_multi_pkg;

   localparam logic [1:0] ST_ARB_IDLE = 2'd0;
   localparam logic [1:0] ST_ARB_A1   = 2'd1;
   localparam logic [1:0] ST_ARB_A2   = 2'd2;

   // Cycles from address presentation to read data capture. The sequencer
   // is built around this fixed value.
   localparam int unsigned MEM_LAT = 2;

   // Reads must never assert byte enables on the memory.
   function automatic logic [3:0] be_for_cmd(input logic we, input logic [3:0] be);
      return we ? be : 4'b0000;
   endfunction

endpackage

// File: rtl/mem_arbiter_multi_rr_pick2.sv
// rr_pick2
// Combinational 2-way round-robin winner selection.
//   req0_i, req1_i : request from port 0 / port 1
//   last_i         : port granted most recently
//   valid_o        : at least one port is requesting
//   win_o          : winning port (0/1), meaningful when valid_o is set
module rr_pick2 (
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_i,
   output logic valid_o,
   output logic win_o
);

   always_comb begin
      valid_o = req0_i | req1_i;
      // On a tie the port not granted last wins; otherwise the lone requester.
      if (req0_i && req1_i) begin
         win_o = ~last_i;
      end else begin
         win_o = req1_i;
      end
   end

endmodule

// File: rtl/mem_arbiter_multi.sv
// mem_arbiter_multi
// Arbitrates a processor port (0) and an auxiliary port (1) onto the single
// shared memory and sequences each access over two cycles (A1, A2).
//   iCLK, iRST             : clock, synchronous active-low reset
//   iReq/iWe/iAddr/iWData/iBe{0,1} : per-port request, held until oAck
//   oAck{0,1}              : one-cycle pulse when the request is captured
//   oRValid{0,1}, oRData   : per-port read strobe, shared registered read data
//   oMemAddr/oMemWData/oMemWE/oMemBE, iMemRData : memory port
//   oGrant                 : port of the current or last access
//   oBusy                  : access in progress
module mem_arbiter_multi
   import mem_arbiter_multi_pkg::*;
#(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic          iReq0,
   input  logic          iWe0,
   input  logic [AW-1:0] iAddr0,
   input  logic [DW-1:0] iWData0,
   input  logic [3:0]    iBe0,
   input  logic          iReq1,
   input  logic          iWe1,
   input  logic [AW-1:0] iAddr1,
   input  logic [DW-1:0] iWData1,
   input  logic [3:0]    iBe1,
   output logic          oAck0,
   output logic          oAck1,
   output logic          oRValid0,
   output logic          oRValid1,
   output logic [DW-1:0] oRData,
   output logic [AW-1:0] oMemAddr,
   output logic [DW-1:0] oMemWData,
   output logic          oMemWE,
   output logic [3:0]    oMemBE,
   input  logic [DW-1:0] iMemRData,
   output logic          oGrant,
   output logic          oBusy
);

   logic [1:0]    state_q, state_d;
   logic          last_q, last_d;
   logic          grant_q, grant_d;
   logic          cmd_we_q, cmd_we_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic          rv0_q, rv0_d;
   logic          rv1_q, rv1_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          we_q, we_d;
   logic [3:0]    be_q, be_d;
   logic          busy_q, busy_d;

   logic          arb_en;
   logic          pick_valid;
   logic          pick_win;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic [3:0]    sel_be;

   rr_pick2 u_rr_pick2 (
      .req0_i  (iReq0),
      .req1_i  (iReq1),
      .last_i  (last_q),
      .valid_o (pick_valid),
      .win_o   (pick_win)
   );

   always_comb begin
      sel_we    = pick_win ? iWe1    : iWe0;
      sel_addr  = pick_win ? iAddr1  : iAddr0;
      sel_wdata = pick_win ? iWData1 : iWData0;
      sel_be    = pick_win ? iBe1    : iBe0;
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      grant_d  = grant_q;
      cmd_we_d = cmd_we_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      rv0_d    = 1'b0;
      rv1_d    = 1'b0;
      rdata_d  = rdata_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = 1'b0;
      be_d     = 4'b0000;
      busy_d   = 1'b0;
      arb_en   = 1'b0;

      case (state_q)
         ST_ARB_IDLE: begin
            arb_en = 1'b1;
         end
         ST_ARB_A1: begin
            state_d = ST_ARB_A2;
            busy_d  = 1'b1;
         end
         ST_ARB_A2: begin
            // Read data is valid while in A2; the owner is the last grant.
            if (!cmd_we_q) begin
               rdata_d = iMemRData;
               rv0_d   = ~last_q;
               rv1_d   = last_q;
            end
            state_d = ST_ARB_IDLE;
            arb_en  = 1'b1;
         end
         default: begin
            state_d = ST_ARB_IDLE;
         end
      endcase

      // Requests are only sampled in IDLE and A2, so an A2 hand-off starts
      // the next A1 without an idle bubble.
      if (arb_en && pick_valid) begin
         state_d  = ST_ARB_A1;
         busy_d   = 1'b1;
         last_d   = pick_win;
         grant_d  = pick_win;
         cmd_we_d = sel_we;
         ack0_d   = ~pick_win;
         ack1_d   = pick_win;
         addr_d   = sel_addr;
         wdata_d  = sel_wdata;
         we_d     = sel_we;
         be_d     = be_for_cmd(sel_we, sel_be);
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         state_q  <= ST_ARB_IDLE;
         last_q   <= 1'b1;
         grant_q  <= 1'b0;
         cmd_we_q <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rv0_q    <= 1'b0;
         rv1_q    <= 1'b0;
         rdata_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         be_q     <= 4'b0000;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         cmd_we_q <= cmd_we_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         rv0_q    <= rv0_d;
         rv1_q    <= rv1_d;
         rdata_q  <= rdata_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         be_q     <= be_d;
         busy_q   <= busy_d;
      end
   end

   assign oAck0     = ack0_q;
   assign oAck1     = ack1_q;
   assign oRValid0  = rv0_q;
   assign oRValid1  = rv1_q;
   assign oRData    = rdata_q;
   assign oMemAddr  = addr_q;
   assign oMemWData = wdata_q;
   assign oMemWE    = we_q;
   assign oMemBE    = be_q;
   assign oGrant    = grant_q;
   assign oBusy     = busy_q;

endmodule
